// File: rtl/ssd_reader_if.sv
// ssd_reader_if
//   Capture-record stream produced by ssd_reader.
//   master (producer, ssd_reader):
//     out_valid  out  1  a capture record is held and offered
//     out_ready  in   1  consumer takes the record when out_valid && out_ready
//     out_idx    out  3  digit position the record belongs to
//     out_val    out  4  decoded hex value (0 for a blank record)
//     out_blank  out  1  record came from the all-segments-off pattern
//   slave (consumer): same signals, opposite directions.
interface ssd_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [3:0] out_val;
  logic       out_blank;

  modport master (
    output out_valid,
    output out_idx,
    output out_val,
    output out_blank,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_val,
    input  out_blank,
    output out_ready
  );
endinterface

// File: rtl/ssd_reader.sv
// ssd_reader
//   Watches a multiplexed, active-low seven-segment bus and recovers the hex
//   digit shown on each position. A (digit select, segment) pair has to be
//   seen unchanged for STABLE_CYCLES samples before it is believed, so scan
//   transitions and ghosting never produce a capture. Each qualified pair is
//   committed once; it is re-captured only after the bus changes and settles
//   again.
// Ports
//   clk          in   1             rising-edge clock
//   reset        in   1             synchronous, active-high
//   seg_n        in   7             segments, active-low, bit0=a .. bit6=g
//   an_n         in   NUM_DIGITS    digit selects, active-low
//   digits       out  4*NUM_DIGITS  last legal value per digit, digit i at [4i+3:4i]
//   digit_valid  out  NUM_DIGITS    digits[i] holds a legal decode
//   rec          master            capture-record stream (valid/ready)
//   overrun      out  1             sticky: a record was dropped because the
//                                   holding register was full
//   err_cnt      out  ERR_W         saturating count of illegal-pattern captures
module ssd_reader #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  ssd_reader_if.master            rec,
  output logic                    overrun,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]      STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
  localparam logic [6:0]            SEG_OFF  = 7'h7F;
  localparam logic [ERR_W-1:0]      ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Segment pattern (g..a, active-low) to {legal, value}. Blank is handled
  // separately because it is a valid record but not a value.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // True when exactly one select line is driven low.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] a);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!a[i]) begin
        n = n + 1;
      end else begin
        n = n;
      end
    end
    return (n == 1);
  endfunction

  // Position of the low select line; only meaningful when one_low() holds.
  function automatic logic [2:0] low_idx(input logic [NUM_DIGITS-1:0] a);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!a[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Input sample stage and tracking state
  logic [6:0]            s_seg_r;
  logic [NUM_DIGITS-1:0] s_an_r;
  logic [6:0]            prev_seg_r;
  logic [NUM_DIGITS-1:0] prev_an_r;
  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;

  // Output registers
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   digit_valid_r;
  logic [ERR_W-1:0]        err_cnt_r;
  logic                    overrun_r;
  logic                    rec_valid_r;
  logic [2:0]              rec_idx_r;
  logic [3:0]              rec_val_r;
  logic                    rec_blank_r;

  // Combinational helpers
  logic       onehot_s;
  logic       same_s;
  state_t     restart_state_s;
  logic [4:0] dec_s;
  logic       cap_legal_s;
  logic       cap_blank_s;
  logic [2:0] cap_idx_s;
  logic       commit_s;
  logic       push_s;
  logic       accept_s;
  logic       load_s;

  // Pair comparison, decode of the qualified pair and record handshake terms.
  always_comb begin
    onehot_s        = one_low(s_an_r);
    same_s          = (s_seg_r == prev_seg_r) && (s_an_r == prev_an_r);
    // A changed pair either starts a new qualification run or, if no single
    // digit is selected, drops back to waiting.
    if (!onehot_s) begin
      restart_state_s = IDLE;
    end else if (STABLE_CYCLES == 1) begin
      restart_state_s = CAPTURE;
    end else begin
      restart_state_s = TRACK;
    end
    dec_s       = seg_decode(prev_seg_r);
    cap_legal_s = dec_s[4];
    cap_blank_s = (prev_seg_r == SEG_OFF);
    cap_idx_s   = low_idx(prev_an_r);
    commit_s    = (state_r == CAPTURE);
    push_s      = commit_s && (cap_legal_s || cap_blank_s);
    accept_s    = rec_valid_r && rec.out_ready;
    // The holding register can take a new record when empty or when its
    // current record leaves in this same cycle.
    load_s      = push_s && (!rec_valid_r || accept_s);
  end

  // Input sampling and the qualification state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg_r    <= SEG_OFF;
      s_an_r     <= AN_OFF;
      prev_seg_r <= SEG_OFF;
      prev_an_r  <= AN_OFF;
      cnt_r      <= CNT_ZERO;
      state_r    <= IDLE;
    end else begin
      s_seg_r <= seg_n;
      s_an_r  <= an_n;
      case (state_r)
        IDLE: begin
          if (onehot_s) begin
            prev_seg_r <= s_seg_r;
            prev_an_r  <= s_an_r;
            cnt_r      <= CNT_ONE;
            state_r    <= restart_state_s;
          end else begin
            state_r <= IDLE;
          end
        end
        TRACK: begin
          if (same_s) begin
            if ((cnt_r + CNT_ONE) == STABLE_C) begin
              cnt_r   <= STABLE_C;
              state_r <= CAPTURE;
            end else begin
              cnt_r   <= cnt_r + CNT_ONE;
              state_r <= TRACK;
            end
          end else begin
            prev_seg_r <= s_seg_r;
            prev_an_r  <= s_an_r;
            cnt_r      <= CNT_ONE;
            state_r    <= restart_state_s;
          end
        end
        // The commit itself happens in the output block this cycle. A change
        // that arrives while committing is not lost: it restarts tracking.
        CAPTURE, HOLD: begin
          if (same_s) begin
            state_r <= HOLD;
          end else begin
            prev_seg_r <= s_seg_r;
            prev_an_r  <= s_an_r;
            cnt_r      <= CNT_ONE;
            state_r    <= restart_state_s;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Commit of a qualified pair into the per-digit view and the record stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_r      <= {(4*NUM_DIGITS){1'b0}};
      digit_valid_r <= {NUM_DIGITS{1'b0}};
      err_cnt_r     <= {ERR_W{1'b0}};
      overrun_r     <= 1'b0;
      rec_valid_r   <= 1'b0;
      rec_idx_r     <= 3'd0;
      rec_val_r     <= 4'h0;
      rec_blank_r   <= 1'b0;
    end else begin
      if (commit_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (3'(i) == cap_idx_s) begin
            // Blank and illegal patterns leave the last value in place but
            // mark it as no longer being shown.
            if (cap_legal_s) begin
              digits_r[4*i +: 4] <= dec_s[3:0];
              digit_valid_r[i]   <= 1'b1;
            end else begin
              digit_valid_r[i]   <= 1'b0;
            end
          end
        end
        if (!cap_legal_s && !cap_blank_s && (err_cnt_r != ERR_MAX)) begin
          err_cnt_r <= err_cnt_r + ERR_W'(1);
        end
      end

      if (load_s) begin
        rec_valid_r <= 1'b1;
        rec_idx_r   <= cap_idx_s;
        rec_val_r   <= cap_legal_s ? dec_s[3:0] : 4'h0;
        rec_blank_r <= cap_blank_s;
      end else if (push_s) begin
        // Full and not draining: keep the held record, flag the loss.
        overrun_r <= 1'b1;
      end else if (accept_s) begin
        rec_valid_r <= 1'b0;
      end
    end
  end

  assign digits        = digits_r;
  assign digit_valid   = digit_valid_r;
  assign err_cnt       = err_cnt_r;
  assign overrun       = overrun_r;
  assign rec.out_valid = rec_valid_r;
  assign rec.out_idx   = rec_idx_r;
  assign rec.out_val   = rec_val_r;
  assign rec.out_blank = rec_blank_r;

endmodule

// File: tb/tb_ssd_reader.sv
// Testbench for ssd_reader (NUM_DIGITS=2, STABLE_CYCLES=4, ERR_W=8).
// The reference model tracks how long each (select, segment) pair has been
// on the bus; a one-hot pair whose run reaches STABLE_CYCLES is committed two
// clocks after that sample. Records flow through a one-entry holding model.
module tb_ssd_reader;
  localparam int ND     = 2;
  localparam int STABLE = 4;

  localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                      7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                      7'h46, 7'h21, 7'h06, 7'h0E};

  logic          clk;
  logic          reset;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [7:0]    digits;
  logic [ND-1:0] digit_valid;
  logic          overrun;
  logic [7:0]    err_cnt;

  ssd_reader_if rif();

  ssd_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE), .ERR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .rec         (rif.master),
    .overrun     (overrun),
    .err_cnt     (err_cnt)
  );

  int vectors;
  int miscompares;

  // Reference model state
  logic [7:0]    m_digits;
  logic [ND-1:0] m_dv;
  logic [7:0]    m_err;
  logic          m_ov;
  logic [2:0]    m_idx;
  logic [3:0]    m_val;
  logic          m_blank;
  logic          m_overrun;
  logic [6:0]    m_seg;
  logic [ND-1:0] m_an;
  int            m_run;
  logic          m_pend;
  logic [6:0]    m_pseg;
  logic [ND-1:0] m_pan;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 0..15 = hex value, 16 = blank, -1 = illegal
  function automatic int dec(input logic [6:0] s);
    for (int k = 0; k < 16; k++) begin
      if (s == TBL[k]) return k;
    end
    if (s == 7'h7F) return 16;
    return -1;
  endfunction

  function automatic bit onehot_low(input logic [ND-1:0] a);
    return ($countones(~a) == 1);
  endfunction

  function automatic logic [27:0] dut_vec();
    return {digits, digit_valid, err_cnt, rif.out_valid, rif.out_idx,
            rif.out_val, rif.out_blank, overrun};
  endfunction

  function automatic logic [27:0] mdl_vec();
    return {m_digits, m_dv, m_err, m_ov, m_idx, m_val, m_blank, m_overrun};
  endfunction

  // Advance the model by one clock edge given the inputs present at it.
  task automatic model_step(input bit rst, input logic [6:0] s,
                            input logic [ND-1:0] a, input bit rdy);
    int  d;
    int  pos;
    bit  acc;
    bit  push;
    logic [3:0] pv;
    bit  pb;
    if (rst) begin
      m_digits = 8'h00; m_dv = 2'b00; m_err = 8'h00; m_ov = 1'b0;
      m_idx = 3'd0; m_val = 4'h0; m_blank = 1'b0; m_overrun = 1'b0;
      m_seg = 7'h7F; m_an = 2'b11; m_run = 1; m_pend = 1'b0;
      m_pseg = 7'h7F; m_pan = 2'b11;
      return;
    end
    acc  = m_ov && rdy;
    push = 1'b0;
    pv   = 4'h0;
    pb   = 1'b0;
    if (m_pend) begin
      d   = dec(m_pseg);
      pos = 0;
      for (int j = 0; j < ND; j++) if (!m_pan[j]) pos = j;
      if (d < 0) begin
        m_dv[pos] = 1'b0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end else if (d == 16) begin
        m_dv[pos] = 1'b0;
        push = 1'b1; pv = 4'h0; pb = 1'b1;
      end else begin
        m_digits[4*pos +: 4] = 4'(d);
        m_dv[pos] = 1'b1;
        push = 1'b1; pv = 4'(d); pb = 1'b0;
      end
      if (push) begin
        if (!m_ov || acc) begin
          m_ov = 1'b1; m_idx = 3'(pos); m_val = pv; m_blank = pb;
        end else begin
          m_overrun = 1'b1;
        end
      end
    end
    if (!push && acc) m_ov = 1'b0;
    m_pend = onehot_low(m_an) && (m_run == STABLE);
    if (m_pend) begin
      m_pseg = m_seg;
      m_pan  = m_an;
    end
    if (s == m_seg && a == m_an) begin
      if (m_run < 1000) m_run = m_run + 1;
    end else begin
      m_seg = s; m_an = a; m_run = 1;
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic [ND-1:0] a,
                      input bit rdy, input bit rst);
    seg_n         = s;
    an_n          = a;
    rif.out_ready = rdy;
    reset         = rst;
    model_step(rst, s, a, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] a,
                      input bit rdy, input int n);
    for (int k = 0; k < n; k++) tick(s, a, rdy, 1'b0);
  endtask

  task automatic do_reset();
    tick(7'h7F, 2'b11, 1'b0, 1'b1);
    tick(7'h7F, 2'b11, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) tick(7'($urandom), 2'($urandom), 1'($urandom), 1'b1);
    vectors++;
    if (dut_vec() !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_zero got=%h exp=%h", dut_vec(), 28'h0);
    end
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL reset_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_single_capture();
    do_reset();
    hold(7'h24, 2'b10, 1'b0, 5);
    vectors++;
    if (rif.out_valid !== 1'b0 || digit_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL single_early got valid=%b dv=%b exp valid=0 dv=00",
               rif.out_valid, digit_valid);
    end
    tick(7'h24, 2'b10, 1'b0, 1'b0);
    vectors++;
    if (digits[3:0] !== 4'h2 || digit_valid !== 2'b01 || rif.out_valid !== 1'b1 ||
        rif.out_idx !== 3'd0 || rif.out_val !== 4'h2 || rif.out_blank !== 1'b0) begin
      miscompares++;
      $display("FAIL single_commit got d=%h dv=%b v=%b idx=%0d val=%h exp d=2 dv=01 v=1 idx=0 val=2",
               digits[3:0], digit_valid, rif.out_valid, rif.out_idx, rif.out_val);
    end
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL single_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      hold((k % 2 == 0) ? 7'h24 : 7'h30, 2'b01, 1'b0, 2);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL glitch_model got=%h exp=%h", dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (rif.out_valid !== 1'b0 || digit_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL glitch_nocap got valid=%b dv=%b exp 0 00", rif.out_valid, digit_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    hold(7'h7E, 2'b01, 1'b1, 7);
    vectors++;
    if (err_cnt !== 8'd1 || digit_valid[1] !== 1'b0 || rif.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_first got err=%0d dv1=%b v=%b exp err=1 dv1=0 v=0",
               err_cnt, digit_valid[1], rif.out_valid);
    end
    for (int k = 0; k < 258; k++) hold((k % 2 == 0) ? 7'h7D : 7'h7E, 2'b01, 1'b1, 5);
    hold(7'h7F, 2'b11, 1'b1, 3);
    vectors++;
    if (err_cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL illegal_saturate got=%h exp=%h", err_cnt, 8'hFF);
    end
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL illegal_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_overrun();
    bit found;
    do_reset();
    hold(7'h12, 2'b10, 1'b0, 7);
    hold(7'h08, 2'b01, 1'b0, 7);
    vectors++;
    if (rif.out_valid !== 1'b1 || rif.out_idx !== 3'd0 || rif.out_val !== 4'h5 ||
        overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_drop got v=%b idx=%0d val=%h ovr=%b exp v=1 idx=0 val=5 ovr=1",
               rif.out_valid, rif.out_idx, rif.out_val, overrun);
    end
    vectors++;
    if (dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL overrun_model got=%h exp=%h", dut_vec(), mdl_vec());
    end
    // Full register, consumer accepts exactly on the commit edge.
    do_reset();
    hold(7'h12, 2'b10, 1'b0, 7);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (m_pend) begin
        tick(7'h08, 2'b01, 1'b1, 1'b0);
        found = 1'b1;
      end else begin
        tick(7'h08, 2'b01, 1'b0, 1'b0);
      end
    end
    vectors++;
    if (!found || rif.out_valid !== 1'b1 || rif.out_idx !== 3'd1 ||
        rif.out_val !== 4'hA || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_same_cycle found=%b got v=%b idx=%0d val=%h ovr=%b exp v=1 idx=1 val=a ovr=0",
               found, rif.out_valid, rif.out_idx, rif.out_val, overrun);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      hold(7'h46, 2'b01, 1'b1, 8);
      vectors++;
      if (rif.out_idx !== 3'd1 || rif.out_val !== 4'hC || dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL alternate_d1 got idx=%0d val=%h vec=%h exp idx=1 val=c vec=%h",
                 rif.out_idx, rif.out_val, dut_vec(), mdl_vec());
      end
      hold(7'h12, 2'b10, 1'b1, 8);
      vectors++;
      if (rif.out_idx !== 3'd0 || rif.out_val !== 4'h5 || dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL alternate_d0 got idx=%0d val=%h vec=%h exp idx=0 val=5 vec=%h",
                 rif.out_idx, rif.out_val, dut_vec(), mdl_vec());
      end
    end
    vectors++;
    if (digits !== 8'hC5 || digit_valid !== 2'b11 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL alternate_final got d=%h dv=%b ovr=%b exp d=c5 dv=11 ovr=0",
               digits, digit_valid, overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(7'h21, 2'b10, 1'b0, 4);
    tick(7'h21, 2'b10, 1'b0, 1'b1);
    vectors++;
    if (dut_vec() !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_mid_zero got=%h exp=%h", dut_vec(), 28'h0);
    end
    hold(7'h21, 2'b10, 1'b0, 5);
    vectors++;
    if (rif.out_valid !== 1'b0 || digit_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_requal got v=%b dv=%b exp 0 00", rif.out_valid, digit_valid);
    end
    tick(7'h21, 2'b10, 1'b0, 1'b0);
    vectors++;
    if (digits[3:0] !== 4'hD || digit_valid !== 2'b01 || rif.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_commit got d=%h dv=%b v=%b exp d=d dv=01 v=1",
               digits[3:0], digit_valid, rif.out_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0]    s;
    logic [ND-1:0] a;
    int            n;
    int            sel;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       s = TBL[$urandom_range(0, 15)];
      else if (sel < 8)  s = 7'h7F;
      else               s = 7'($urandom);
      sel = $urandom_range(0, 9);
      a   = (sel < 4) ? 2'b01 : (sel < 8) ? 2'b10 : 2'($urandom);
      n   = $urandom_range(1, 8);
      for (int c = 0; c < n; c++) begin
        tick(s, a, 1'($urandom), ($urandom_range(0, 199) == 0));
        vectors++;
        if (dut_vec() !== mdl_vec()) begin
          miscompares++;
          $display("FAIL random_model step=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    seg_n         = 7'h7F;
    an_n          = 2'b11;
    rif.out_ready = 1'b0;
    model_step(1'b1, 7'h7F, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_single_capture();
    test_glitch();
    test_illegal();
    test_overrun();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
